// File: rtl/mux_pair_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared dual-lane 2:1 mux pair.
// Owns the mux select, moves bursts beat-by-beat into a registered y/z stage.

module mux_pair_lane #(
  parameter int DATA_W = 1
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              ld,
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n)  q <= '0;
    else if (ld)  q <= sel ? d1 : d0;
endmodule

module mux_pair_rr_arbiter #(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req0_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] c_in,
  input  logic              last0_in,
  input  logic              req1_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic              last1_in,
  input  logic              ready_in,
  output logic              ack0_out,
  output logic              ack1_out,
  output logic              sel_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] z_out,
  output logic              valid_out,
  output logic              busy_out
);
  localparam int NUM_LANES = 2;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_nxt;
  logic          ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW:0]   cnt_inc;
  logic          vld, space, ack;
  logic          own_req, own_last, oth_req, at_limit, rel;

  assign space    = !vld | ready_in;
  assign ack0_out = (state == GNT0) & req0_in & space;
  assign ack1_out = (state == GNT1) & req1_in & space;
  assign ack      = ack0_out | ack1_out;
  assign sel_out  = (state == GNT1);
  assign busy_out = (state != IDLE);

  assign own_req  = sel_out ? req1_in  : req0_in;
  assign own_last = sel_out ? last1_in : last0_in;
  assign oth_req  = sel_out ? req0_in  : req1_in;
  assign cnt_inc  = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  assign at_limit = (cnt_inc == LIMIT);
  // Release priority: final beat, forced rotation at limit, requester dropped.
  assign rel      = (ack & own_last) | (ack & at_limit & oth_req) | !own_req;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req0_in & req1_in) state_nxt = ptr ? GNT0 : GNT1;
        else if (req0_in)      state_nxt = GNT0;
        else if (req1_in)      state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (rel) begin
          ptr_nxt   = sel_out;
          cnt_nxt   = '0;
          state_nxt = oth_req ? (sel_out ? GNT0 : GNT1) : IDLE;
        end else if (ack) begin
          // Limit hit with the other side idle: keep the grant, restart the count.
          cnt_nxt = at_limit ? '0 : cnt_inc[CW-1:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      ptr   <= 1'b1;
      cnt   <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      if (ack)           vld <= 1'b1;
      else if (ready_in) vld <= 1'b0;
    end

  assign valid_out = vld;

  // Lane 0 = y (a/b), lane 1 = z (c/d).
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_d0, lane_d1, lane_q;
  assign lane_d0 = {c_in, a_in};
  assign lane_d1 = {d_in, b_in};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mux_pair_lane #(.DATA_W(DATA_W)) u_lane (
      .gclk   (clk_in),
      .grst_n (rst_n_in),
      .ld     (ack),
      .sel    (sel_out),
      .d0     (lane_d0[g]),
      .d1     (lane_d1[g]),
      .q      (lane_q[g])
    );
  end

  assign y_out = lane_q[0];
  assign z_out = lane_q[1];
endmodule

// File: tb/tb_mux_pair_rr_arbiter.sv
// Directed + random bench for mux_pair_rr_arbiter against a rule-level reference model.
module tb_mux_pair_rr_arbiter;
  localparam int DW   = 4;
  localparam int MAXB = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          req0_in, last0_in, req1_in, last1_in, ready_in;
  logic [DW-1:0] a_in, b_in, c_in, d_in;
  logic          ack0_out, ack1_out, sel_out, valid_out, busy_out;
  logic [DW-1:0] y_out, z_out;

  mux_pair_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req0_in(req0_in), .a_in(a_in), .c_in(c_in), .last0_in(last0_in),
    .req1_in(req1_in), .b_in(b_in), .d_in(d_in), .last1_in(last1_in),
    .ready_in(ready_in),
    .ack0_out(ack0_out), .ack1_out(ack1_out), .sel_out(sel_out),
    .y_out(y_out), .z_out(z_out), .valid_out(valid_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0, fails = 0;
  // Reference model: owner -1 = nobody, 0/1 = requester; ptr = last releaser.
  int            m_own, m_ptr, m_cnt;
  logic          m_v;
  logic [DW-1:0] m_y, m_z;
  logic          e_ack0, e_ack1, obs_ack0, obs_ack1, obs_sel;
  int            recv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_own = -1; m_ptr = 1; m_cnt = 0; m_v = 1'b0; m_y = '0; m_z = '0;
  endtask

  // Called just after a negedge with inputs applied; returns after the next negedge.
  task automatic cyc();
    logic me_req, me_last, o_req, ak;
    int beats;
    #1;
    e_ack0 = (m_own == 0) && req0_in && (!m_v || ready_in);
    e_ack1 = (m_own == 1) && req1_in && (!m_v || ready_in);
    obs_ack0 = ack0_out; obs_ack1 = ack1_out; obs_sel = sel_out;
    chk("ack0",  ack0_out,  e_ack0);
    chk("ack1",  ack1_out,  e_ack1);
    chk("sel",   sel_out,   m_own == 1);
    chk("busy",  busy_out,  m_own != -1);
    chk("valid", valid_out, m_v);
    chk("y",     y_out,     m_y);
    chk("z",     z_out,     m_z);
    if (valid_out && ready_in) recv++;
    @(posedge clk_in);
    ak = e_ack0 || e_ack1;
    if (ak) begin
      m_y = (m_own == 1) ? b_in : a_in;
      m_z = (m_own == 1) ? d_in : c_in;
      m_v = 1'b1;
    end else if (ready_in) m_v = 1'b0;
    if (m_own < 0) begin
      m_cnt = 0;
      if (req0_in && req1_in) m_own = (m_ptr == 0) ? 1 : 0;
      else if (req0_in)       m_own = 0;
      else if (req1_in)       m_own = 1;
    end else begin
      me_req  = (m_own == 0) ? req0_in  : req1_in;
      me_last = (m_own == 0) ? last0_in : last1_in;
      o_req   = (m_own == 0) ? req1_in  : req0_in;
      beats   = m_cnt + 1;
      if ((ak && me_last) || (ak && beats == MAXB && o_req) || !me_req) begin
        m_ptr = m_own;
        m_own = o_req ? 1 - m_own : -1;
        m_cnt = 0;
      end else if (ak) m_cnt = (beats == MAXB) ? 0 : beats;
    end
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    req0_in = 0; req1_in = 0; last0_in = 0; last1_in = 0; ready_in = 1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_reset_outs();
    chk("rst_ack0", ack0_out, 0); chk("rst_ack1", ack1_out, 0);
    chk("rst_sel", sel_out, 0);   chk("rst_busy", busy_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_y", y_out, 0);       chk("rst_z", z_out, 0);
  endtask

  initial begin
    int n0, n1, first, lastc, sent, cyc_n;
    logic alt_ok;
    int prev;
    rst_n_in = 1; req0_in = 0; req1_in = 0; last0_in = 0; last1_in = 0;
    ready_in = 1; a_in = '0; b_in = '0; c_in = '0; d_in = '0; recv = 0;
    m_reset();
    #2 rst_n_in = 0;
    #1 chk_reset_outs();
    @(negedge clk_in); @(negedge clk_in);
    rst_n_in = 1;
    idle(2);

    // Single burst of 3 beats from requester 0
    req0_in = 1; a_in = 1; c_in = 0; n0 = 0; first = -1; lastc = -1;
    for (int i = 0; i < 10 && n0 < 3; i++) begin
      last0_in = (n0 == 2);
      cyc();
      if (obs_ack0) begin if (first < 0) first = i; lastc = i; n0++; end
    end
    chk("t2_beats", n0, 3);
    chk("t2_contig", lastc - first, 2);
    chk("t2_first", first, 1);
    idle(2);
    chk("t2_idle_busy", busy_out, 0);

    // Tie with last on every beat: strict alternation, no bubble
    req0_in = 1; req1_in = 1; last0_in = 1; last1_in = 1;
    a_in = 4'h3; c_in = 4'h5; b_in = 4'hA; d_in = 4'hC;
    n0 = 0; prev = -1; alt_ok = 1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (obs_ack0 || obs_ack1) begin
        n0++;
        if (prev == int'(obs_ack1)) alt_ok = 0;
        prev = int'(obs_ack1);
      end
    end
    chk("t3_acks", n0, 6);
    chk("t3_alternate", alt_ok, 1);
    idle(2);

    // Reset while GNT1 holds a valid beat; tie afterwards goes to requester 0
    req1_in = 1; last1_in = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("t1_pre_valid", valid_out, 1);
    rst_n_in = 0;
    #1 chk_reset_outs();
    m_reset();
    @(negedge clk_in);
    req0_in = 1; req1_in = 1; last0_in = 1; last1_in = 1;
    rst_n_in = 1;
    cyc();
    #1 chk("t1_sel_first", sel_out, 0);
    chk("t1_ack0_first", ack0_out, 1);
    cyc();
    idle(2);

    // Burst limit with contention: exactly MAXB beats then rotation
    req0_in = 1; last0_in = 0;
    cyc();
    req1_in = 1; n0 = 0; obs_ack1 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (obs_ack1) break;
      if (obs_ack0) n0++;
    end
    chk("t4_ack0_cnt", n0, MAXB);
    chk("t4_rot_ack1", obs_ack1, 1);
    chk("t4_rot_sel", obs_sel, 1);
    idle(3);

    // Backpressure mid-burst: nothing lost or duplicated
    recv = 0; sent = 0;
    req0_in = 1; last0_in = 0;
    for (int i = 0; i < 3; i++) begin
      a_in = DW'($urandom); c_in = DW'($urandom); cyc(); sent += int'(obs_ack0);
    end
    ready_in = 0;
    for (int i = 0; i < 3; i++) begin
      a_in = DW'($urandom); c_in = DW'($urandom); cyc(); sent += int'(obs_ack0);
    end
    ready_in = 1;
    for (int i = 0; i < 2; i++) begin
      a_in = DW'($urandom); c_in = DW'($urandom); cyc(); sent += int'(obs_ack0);
    end
    last0_in = 1; a_in = DW'($urandom); c_in = DW'($urandom);
    cyc(); sent += int'(obs_ack0);
    idle(3);
    chk("t5_sent", sent, 5);
    chk("t5_recv", recv, sent);

    // No contention: 10 contiguous beats despite MAXB=4
    req0_in = 1; last0_in = 0;
    cyc();
    n0 = 0; cyc_n = 0;
    for (int i = 0; i < 15 && n0 < 10; i++) begin
      last0_in = (n0 == 9); a_in = DW'($urandom); c_in = DW'($urandom);
      cyc(); cyc_n++;
      if (obs_ack0) n0++;
    end
    chk("t6_beats", n0, 10);
    chk("t6_cycles", cyc_n, 10);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req0_in  = ($urandom_range(0, 3) != 0);
      req1_in  = ($urandom_range(0, 3) != 0);
      last0_in = ($urandom_range(0, 3) == 0);
      last1_in = ($urandom_range(0, 3) == 0);
      ready_in = ($urandom_range(0, 3) != 0);
      a_in = DW'($urandom); b_in = DW'($urandom);
      c_in = DW'($urandom); d_in = DW'($urandom);
      cyc();
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
